clock_monitor: RTL and testbench

- Consumer-side check for a generated clock. Samples a probe clock (e.g. the divided VGA clock) in the local clock domain and counts its rising edges over a fixed window of local cycles.
- Reports frequency lock with hysteresis, plus fast detection of a stopped probe.
- Sits beside the clock generator. Feeds status LEDs/debug logic and can hold downstream logic in reset until the derived clock is proven good.

---
 rtl/clock_monitor.sv | 209 ++++++++++++++++++++
 tb/tb_clock_monitor.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_monitor.sv
// clock_monitor
//   Consumer-side sanity check for a generated clock. The probe clock is
//   sampled as data in the local clk domain. Its rising edges are counted over
//   a fixed window of WINDOW clk cycles. The monitor reports frequency lock
//   with hysteresis, and it detects a stopped probe quickly.
//
// Optional feature (macro CLOCK_MONITOR_STICKY_ERR_EN):
//   Adds err_clear/err_sticky. err_sticky latches every loss of lock and
//   every onset of probe_dead. err_clear releases it, and a new set event
//   in the same cycle wins over the clear.
//
// Ports:
//   clk          local reference clock (posedge)
//   reset_n      asynchronous active-low reset
//   enable       monitor enable; low holds the monitor idle (SETTLE)
//   probe        asynchronous probe clock, sampled as data
//   freq_ok      probe frequency in range and locked
//   probe_dead   no probe rising edge for STALL_CYCLES cycles
//   meas_count   edge count of the last completed window
//   meas_valid   one-cycle pulse when meas_count updates (not for SETTLE)
//   o_dbg_state  current FSM state (SETTLE=0, CHECK=1, LOCKED=2)
//   err_clear    (optional) synchronous clear of err_sticky
//   err_sticky   (optional) sticky error flag
module clock_monitor #(
   parameter int WINDOW       = 1024,
   parameter int CNT_W        = 11,
   parameter int EXPECTED     = 512,
   parameter int TOL          = 4,
   parameter int GOOD_WINDOWS = 2,
   parameter int STALL_CYCLES = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             enable,
   input  logic             probe,
`ifdef CLOCK_MONITOR_STICKY_ERR_EN
   input  logic             err_clear,
   output logic             err_sticky,
`endif
   output logic             freq_ok,
   output logic             probe_dead,
   output logic [CNT_W-1:0] meas_count,
   output logic             meas_valid,
   output logic [1:0]       o_dbg_state
);

   localparam int WCNT_W = $clog2(WINDOW);
   localparam int SCNT_W = $clog2(STALL_CYCLES + 1);
   localparam int GCNT_W = $clog2(GOOD_WINDOWS + 1);
   // The lower bound is clamped at zero so that small EXPECTED values
   // cannot wrap.
   localparam logic [31:0] LO_BOUND = (EXPECTED >= TOL) ? 32'(EXPECTED - TOL) : 32'd0;
   localparam logic [31:0] HI_BOUND = 32'(EXPECTED + TOL);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic [1:0] {
      SETTLE = 2'd0,
      CHECK  = 2'd1,
      LOCKED = 2'd2
   } state_t;

   logic              r_s1, r_s2, r_s3;
   logic              w_rise;
   logic [WCNT_W-1:0] r_wcnt;
   logic              w_eow;
   logic [CNT_W-1:0]  r_edge_cnt;
   logic [CNT_W-1:0]  w_close_cnt;
   logic [31:0]       w_close_ext;
   logic              w_in_range;
   logic [SCNT_W-1:0] r_scnt;
   logic              w_stall_set;
   logic              r_probe_dead;
   logic [CNT_W-1:0]  r_meas_count;
   logic              r_meas_valid;
   state_t            r_state, w_state_nxt;
   logic [GCNT_W-1:0] r_good_cnt, w_good_nxt;

   // rise is the first cycle in which the synchronised probe is seen high.
   assign w_rise = r_s2 & ~r_s3;
   assign w_eow  = enable && (r_wcnt == WCNT_W'(WINDOW - 1));

   // The running count, including this cycle's rise, with saturation. At
   // end-of-window this value is the published measurement. In other
   // cycles it is the next edge count.
   assign w_close_cnt = (w_rise && (r_edge_cnt != CNT_MAX)) ? r_edge_cnt + 1'b1 : r_edge_cnt;
   assign w_close_ext = {{(32-CNT_W){1'b0}}, w_close_cnt};
   assign w_in_range  = (w_close_ext >= LO_BOUND) && (w_close_ext <= HI_BOUND);

   // This fires once, at the onset of a stall. A rise in the same cycle
   // cancels the stall.
   assign w_stall_set = enable && (r_scnt == SCNT_W'(STALL_CYCLES)) && !w_rise && !r_probe_dead;

   always_comb begin
      w_state_nxt = r_state;
      w_good_nxt  = r_good_cnt;
      case (r_state)
         SETTLE: begin
            if (w_eow) begin
               w_state_nxt = CHECK;
               w_good_nxt  = '0;
            end
         end
         CHECK: begin
            // A stall takes priority over a window result in the same cycle.
            if (w_stall_set) begin
               w_good_nxt = '0;
            end else if (w_eow) begin
               if (!w_in_range) begin
                  w_good_nxt = '0;
               end else if ((r_good_cnt + 1'b1) == GCNT_W'(GOOD_WINDOWS)) begin
                  w_state_nxt = LOCKED;
                  w_good_nxt  = '0;
               end else begin
                  w_good_nxt = r_good_cnt + 1'b1;
               end
            end
         end
         LOCKED: begin
            if (w_stall_set || (w_eow && !w_in_range)) begin
               w_state_nxt = CHECK;
               w_good_nxt  = '0;
            end
         end
         default: begin
            w_state_nxt = SETTLE;
            w_good_nxt  = '0;
         end
      endcase
      if (!enable) begin
         w_state_nxt = SETTLE;
         w_good_nxt  = '0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_s1         <= 1'b0;
         r_s2         <= 1'b0;
         r_s3         <= 1'b0;
         r_wcnt       <= '0;
         r_edge_cnt   <= '0;
         r_scnt       <= '0;
         r_probe_dead <= 1'b0;
         r_meas_count <= '0;
         r_meas_valid <= 1'b0;
         r_state      <= SETTLE;
         r_good_cnt   <= '0;
      end else begin
         r_s1       <= probe;
         r_s2       <= r_s1;
         r_s3       <= r_s2;
         r_state    <= w_state_nxt;
         r_good_cnt <= w_good_nxt;
         if (!enable) begin
            r_wcnt       <= '0;
            r_edge_cnt   <= '0;
            r_scnt       <= '0;
            r_probe_dead <= 1'b0;
            r_meas_valid <= 1'b0;
         end else begin
            // WINDOW is a power of two, so the natural wrap closes the window.
            r_wcnt       <= r_wcnt + 1'b1;
            r_meas_valid <= w_eow && (r_state != SETTLE);
            if (w_eow) begin
               r_edge_cnt   <= '0;
               r_meas_count <= w_close_cnt;
            end else begin
               r_edge_cnt <= w_close_cnt;
            end
            if (w_rise) begin
               r_scnt <= '0;
            end else if (r_scnt != SCNT_W'(STALL_CYCLES)) begin
               r_scnt <= r_scnt + 1'b1;
            end
            if (w_rise) begin
               r_probe_dead <= 1'b0;
            end else if (w_stall_set) begin
               r_probe_dead <= 1'b1;
            end
         end
      end
   end

`ifdef CLOCK_MONITOR_STICKY_ERR_EN
   logic w_err_set;
   logic r_err_sticky;

   assign w_err_set = ((r_state == LOCKED) && (w_state_nxt == CHECK)) || w_stall_set;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_err_sticky <= 1'b0;
      end else if (w_err_set) begin
         r_err_sticky <= 1'b1;
      end else if (err_clear) begin
         r_err_sticky <= 1'b0;
      end
   end

   assign err_sticky = r_err_sticky;
`endif

   assign freq_ok     = (r_state == LOCKED);
   assign probe_dead  = r_probe_dead;
   assign meas_count  = r_meas_count;
   assign meas_valid  = r_meas_valid;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_clock_monitor.sv
`timescale 1ns/1ps
module tb_clock_monitor;

   localparam int CNT_W  = 11;
   localparam int WINDOW = 1024;
   localparam logic [CNT_W:0] DC = 12'h800;   // "any count" marker in exp_q

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             reset_n, enable, enable2, probe;
   logic             freq_ok, probe_dead, meas_valid;
   logic [CNT_W-1:0] meas_count;
   logic [1:0]       dbg_state;
   logic             freq_ok2, probe_dead2, meas_valid2;
   logic [CNT_W-1:0] meas_count2;
   logic [1:0]       dbg_state2;
`ifdef CLOCK_MONITOR_STICKY_ERR_EN
   logic err_clear, err_sticky, err_clear2, err_sticky2;
`endif

   clock_monitor dut (
      .clk(clk), .reset_n(reset_n), .enable(enable), .probe(probe),
`ifdef CLOCK_MONITOR_STICKY_ERR_EN
      .err_clear(err_clear), .err_sticky(err_sticky),
`endif
      .freq_ok(freq_ok), .probe_dead(probe_dead), .meas_count(meas_count),
      .meas_valid(meas_valid), .o_dbg_state(dbg_state)
   );

   clock_monitor #(.EXPECTED(300), .TOL(4)) dut2 (
      .clk(clk), .reset_n(reset_n), .enable(enable2), .probe(probe),
`ifdef CLOCK_MONITOR_STICKY_ERR_EN
      .err_clear(err_clear2), .err_sticky(err_sticky2),
`endif
      .freq_ok(freq_ok2), .probe_dead(probe_dead2), .meas_count(meas_count2),
      .meas_valid(meas_valid2), .o_dbg_state(dbg_state2)
   );

   int n_checks = 0;
   int n_errors = 0;
   logic [CNT_W:0] exp_q[$];
   logic seen_ok, seen_dead;

   // Probe generator. Modes: 0 = low, 1 = clk/2, 2 = clk/4, 3 = exactly
   // pat_n single-cycle pulses per 1024 cycles, spread evenly.
   int mode = 0;
   int ph = 0;
   int pat_n = 0;
   initial begin
      probe = 1'b0;
      forever begin
         @(negedge clk);
         case (mode)
            1: probe = ph[0];
            2: probe = ph[1];
            3: probe = (((ph * pat_n) % 1024) < pat_n);
            default: probe = 1'b0;
         endcase
         ph = (ph + 1) % 1024;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic at_neg();
      @(negedge clk);
      #1;
   endtask

   // Scoreboard for the main monitor. Every meas_valid pulse pops one
   // expected count.
   initial begin
      logic [CNT_W:0] e;
      forever begin
         @(posedge clk);
         #1;
         if (meas_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL unexpected_meas_valid: got count %0d, expected no pulse", meas_count);
            end else begin
               e = exp_q.pop_front();
               if (!e[CNT_W]) check("meas_count", 32'(meas_count), 32'(e[CNT_W-1:0]));
            end
         end
      end
   end

   // Queue k expected counts, then wait until the scoreboard has consumed
   // them. Any freq_ok or probe_dead seen meanwhile is recorded.
   task automatic expect_windows(input int k, input logic [CNT_W:0] v);
      int budget;
      budget = (k + 1) * WINDOW + 50;
      repeat (k) exp_q.push_back(v);
      while (exp_q.size() != 0 && budget > 0) begin
         @(posedge clk);
         #2;
         if (freq_ok) seen_ok = 1'b1;
         if (probe_dead) seen_dead = 1'b1;
         budget--;
      end
      if (exp_q.size() != 0) begin
         n_checks++;
         n_errors++;
         $display("FAIL valid_timeout: got %0d pending, expected 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic wait_valid2(output logic ok);
      ok = 1'b0;
      for (int i = 0; i < 2 * WINDOW + 50; i++) begin
         @(posedge clk);
         #1;
         if (meas_valid2) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         n_checks++;
         n_errors++;
         $display("FAIL valid2_timeout: got none, expected meas_valid2 pulse");
      end
   endtask

   // Timing of the path from a fresh start to lock. The caller has just
   // released reset or raised enable on a negedge, and the probe runs at
   // clk/2.
   task automatic lock_timing(input string tag);
      exp_q.push_back(13'(512) >> 1 << 1);
      exp_q.push_back(12'd512);
      for (int c = 1; c <= 3074; c++) begin
         @(posedge clk);
         #1;
         if (c == 1023) check({tag, "_state_settle"}, 32'(dbg_state), 32'd0);
         if (c == 1024) check({tag, "_state_check"}, 32'(dbg_state), 32'd1);
         if (c == 2047) check({tag, "_mv_early"}, 32'(meas_valid), 32'd0);
         if (c == 2048) check({tag, "_mv_first"}, 32'(meas_valid), 32'd1);
         if (c == 2049) check({tag, "_mv_pulse"}, 32'(meas_valid), 32'd0);
         if (c == 3071) check({tag, "_ok_early"}, 32'(freq_ok), 32'd0);
         if (c == 3072) check({tag, "_ok_lock"}, 32'(freq_ok), 32'd1);
         if (c == 3074) check({tag, "_ok_hold"}, 32'(freq_ok), 32'd1);
      end
   endtask

   typedef struct {
      int   n;
      logic exp_lock;
   } vec_t;
   vec_t tbl[5];

   initial begin
      int first_dead;
      logic prev_ok, ok, still_locked, in_rng;
      tbl[0] = '{304, 1'b1};
      tbl[1] = '{305, 1'b0};
      tbl[2] = '{296, 1'b1};
      tbl[3] = '{295, 1'b0};
      tbl[4] = '{300, 1'b1};

      reset_n = 1'b0;
      enable  = 1'b1;
      enable2 = 1'b0;
`ifdef CLOCK_MONITOR_STICKY_ERR_EN
      err_clear  = 1'b0;
      err_clear2 = 1'b0;
`endif
      mode = 1;
      repeat (3) at_neg();
      check("rst_freq_ok", 32'(freq_ok), 32'd0);
      check("rst_probe_dead", 32'(probe_dead), 32'd0);
      check("rst_meas_count", 32'(meas_count), 32'd0);
      check("rst_meas_valid", 32'(meas_valid), 32'd0);
      check("rst_state", 32'(dbg_state), 32'd0);

      // Lock at clk/2 from reset release.
      @(negedge clk);
      reset_n = 1'b1;
      lock_timing("s1");
      seen_ok = 1'b0; seen_dead = 1'b0;
      expect_windows(2, 12'd512);
      check("s1_stays_locked", 32'(freq_ok), 32'd1);
      check("s1_no_dead", 32'(seen_dead), 32'd0);

      // Stall while locked, right after a window closes.
      at_neg();
      mode = 0;
      at_neg();
      first_dead = 0;
      prev_ok = 1'b1;
      for (int c = 1; c <= 25; c++) begin
         @(posedge clk);
         #1;
         if (probe_dead && first_dead == 0) begin
            first_dead = c;
            check("stall_ok_before", 32'(prev_ok), 32'd1);
            check("stall_ok_cleared", 32'(freq_ok), 32'd0);
            check("stall_state_check", 32'(dbg_state), 32'd1);
         end
         prev_ok = freq_ok;
      end
      n_checks++;
      if (first_dead < 17 || first_dead > 19) begin
         n_errors++;
         $display("FAIL stall_latency: got %0d cycles, expected 17..19", first_dead);
      end
`ifdef CLOCK_MONITOR_STICKY_ERR_EN
      check("sticky_set", 32'(err_sticky), 32'd1);
      at_neg();
      err_clear = 1'b1;
      at_neg();
      err_clear = 1'b0;
      check("sticky_clear", 32'(err_sticky), 32'd0);
`endif
      // Restart the probe. The stalled window is partial, then two good
      // windows are needed to lock again.
      exp_q.push_back(DC);
      at_neg();
      mode = 1;
      ok = 1'b0;
      for (int c = 0; c < 8; c++) begin
         @(posedge clk);
         #1;
         if (!probe_dead) ok = 1'b1;
      end
      check("dead_cleared", 32'(ok), 32'd1);
      expect_windows(0, DC);
      expect_windows(1, 12'd512);
      check("relock_w1", 32'(freq_ok), 32'd0);
      expect_windows(1, 12'd512);
      check("relock_w2", 32'(freq_ok), 32'd1);

      // Asynchronous reset in the middle of a window while locked.
      repeat (300) @(posedge clk);
      #3;
      reset_n = 1'b0;
      #1;
      check("async_freq_ok", 32'(freq_ok), 32'd0);
      check("async_meas_count", 32'(meas_count), 32'd0);
      check("async_meas_valid", 32'(meas_valid), 32'd0);
      check("async_probe_dead", 32'(probe_dead), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      lock_timing("rst");

      // Drop enable for 5 cycles while locked.
      at_neg();
      enable = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk);
         #1;
         check("en_low_ok", 32'(freq_ok), 32'd0);
         check("en_low_mv", 32'(meas_valid), 32'd0);
         check("en_low_count", 32'(meas_count), 32'd512);
      end
      @(negedge clk);
      enable = 1'b1;
      lock_timing("en");

      // clk/4 probe: the count is in range of nothing and must never lock.
      at_neg();
      reset_n = 1'b0;
      mode = 2;
      at_neg();
      reset_n = 1'b1;
      seen_ok = 1'b0; seen_dead = 1'b0;
      expect_windows(3, 12'd256);
      check("div4_never_lock", 32'(seen_ok), 32'd0);
      check("div4_never_dead", 32'(seen_dead), 32'd0);

      // Table of exact pulse counts into the EXPECTED=300 monitor.
      for (int r = 0; r < 5; r++) begin
         at_neg();
         reset_n = 1'b0;
         enable  = 1'b0;
         enable2 = 1'b1;
         mode    = 3;
         pat_n   = tbl[r].n;
         ph      = 0;
         at_neg();
         reset_n = 1'b1;
         for (int w = 0; w < 3; w++) begin
            wait_valid2(ok);
            if (ok) begin
               check($sformatf("tbl%0d_count", tbl[r].n), 32'(meas_count2), 32'(tbl[r].n));
               if (w >= 1) check($sformatf("tbl%0d_lock", tbl[r].n), 32'(freq_ok2), 32'(tbl[r].exp_lock));
            end
         end
      end

      // Locked at 304, then 305 pulses per window. Lock is lost at the
      // first out-of-range window.
      at_neg();
      pat_n = 304;
      ph = 0;
      reset_n = 1'b0;
      at_neg();
      reset_n = 1'b1;
      repeat (2) wait_valid2(ok);
      check("drop_locked", 32'(freq_ok2), 32'd1);
      at_neg();
      pat_n = 305;
      still_locked = 1'b1;
      for (int w = 0; w < 3; w++) begin
         wait_valid2(ok);
         if (ok) begin
            in_rng = (meas_count2 >= 11'd296) && (meas_count2 <= 11'd304);
            still_locked = still_locked & in_rng;
            check("drop_track", 32'(freq_ok2), 32'(still_locked));
         end
      end
      check("drop_final_count", 32'(meas_count2), 32'd305);
      check("drop_final_ok", 32'(freq_ok2), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2ms;
      n_checks++;
      n_errors++;
      $display("FAIL watchdog: got timeout, expected completion");
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
